// File: rtl/uart_rcv_pkg.sv
// rtl/uart_rcv_pkg.sv - shared types for the parametrised UART receiver
package uart_rcv_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      STORE  = 3'd5
   } rx_state_t;

endpackage

// File: rtl/uart_rcv_param_fifo.sv
// rtl/uart_rcv_param_fifo.sv - receive buffer; pointers carry one extra wrap bit
module rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              pop_ok;
   logic              push_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign head    = empty ? '1 : mem[rd_ptr[AW-1:0]];
   assign pop_ok  = pop && !empty;
   // a full buffer still accepts a write when the head is popped in the same cycle
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rcv_param.sv
// rtl/uart_rcv_param.sv - parametrised UART receiver with error flags and receive FIFO
module uart_rcv_param
   import uart_rcv_pkg::*;
#(
   parameter int           DATA_W       = 8,
   parameter int           CLKS_PER_BIT = 10,
   parameter parity_mode_t PARITY_MODE  = PAR_EVEN,
   parameter int           STOP_BITS    = 1,
   parameter int           FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   input  logic                          data_read,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun_error,
   output logic                          framing_error,
   output logic                          parity_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_W);
   // start is confirmed just past mid-bit; the first data period is one cycle short
   // so later samples land at mid-bit once synchroniser latency is counted
   localparam logic [CNT_W-1:0] START_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t         state;
   logic [1:0]        sync_q;
   logic [1:0]        sync_vld;
   logic              prev_high;
   logic              rx_s;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_idx;
   logic              stop_idx;
   logic [DATA_W-1:0] shift;
   logic              frame_err;
   logic              par_err;
   logic              bit_done;
   logic              push;
   logic              fifo_empty;
   logic              fifo_full;
   logic              ovr_set;

   assign rx_s     = sync_q[1];
   assign bit_done = (cnt == BIT_CNT);
   assign push     = (state == STORE) && !frame_err && !par_err;
   assign ovr_set  = push && fifo_full && !data_read;

   // prev_high only goes true once the synchroniser holds real line samples,
   // so a line already low when reset releases cannot fake a start edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b11;
         sync_vld  <= 2'b00;
         prev_high <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], serial_in};
         sync_vld  <= {sync_vld[0], 1'b1};
         prev_high <= sync_vld[1] & rx_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         stop_idx      <= 1'b0;
         shift         <= '0;
         frame_err     <= 1'b0;
         par_err       <= 1'b0;
         framing_error <= 1'b0;
         parity_error  <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               if (prev_high && !rx_s) begin
                  state     <= START;
                  cnt       <= '0;
                  bit_idx   <= '0;
                  stop_idx  <= 1'b0;
                  frame_err <= 1'b0;
                  par_err   <= 1'b0;
               end
            end
            START: begin
               if (cnt == START_CNT) begin
                  if (!rx_s) begin
                     state <= DATA;
                     cnt   <= CNT_W'(1);
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DATA: begin
               if (bit_done) begin
                  cnt     <= '0;
                  shift   <= {rx_s, shift[DATA_W-1:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == BIT_W'(DATA_W - 1)) begin
                     state <= (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  cnt     <= '0;
                  par_err <= (^shift) ^ rx_s ^ (PARITY_MODE == PAR_ODD);
                  state   <= STOP;
               end
            end
            STOP: begin
               if (bit_done) begin
                  cnt      <= '0;
                  stop_idx <= stop_idx + 1'b1;
                  if (!rx_s) begin
                     frame_err <= 1'b1;
                  end
                  if (stop_idx == 1'(STOP_BITS - 1)) begin
                     state <= STORE;
                  end
               end
            end
            STORE: begin
               framing_error <= frame_err;
               parity_error  <= par_err;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (ovr_set) begin
            overrun_error <= 1'b1;
         end else if (data_read) begin
            overrun_error <= 1'b0;
         end
      end
   end

   rx_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(shift),
      .pop      (data_read),
      .head     (rx_data),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .count    (fifo_count)
   );

   assign data_ready = !fifo_empty;

endmodule

// File: tb/tb_uart_rcv_param.sv
// tb/tb_uart_rcv_param.sv - directed bench for uart_rcv_param at default parameters
module tb_uart_rcv_param;
   import uart_rcv_pkg::*;

   logic       tb_clk;
   logic       rst;
   logic       serial_in;
   logic       data_read;
   logic [7:0] rx_data;
   logic       data_ready;
   logic [2:0] fifo_count;
   logic       overrun_error;
   logic       framing_error;
   logic       parity_error;

   int checks;
   int failures;

   uart_rcv_param dut (
      .clk          (tb_clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .data_read    (data_read),
      .rx_data      (rx_data),
      .data_ready   (data_ready),
      .fifo_count   (fifo_count),
      .overrun_error(overrun_error),
      .framing_error(framing_error),
      .parity_error (parity_error)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // one frame: start, 8 data bits LSB first, parity, one stop; then two idle bit periods
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int per);
      @(posedge tb_clk);
      #3;
      serial_in = 1'b0;
      #(per);
      for (int i = 0; i < 8; i++) begin
         serial_in = d[i];
         #(per);
      end
      serial_in = par;
      #(per);
      serial_in = stp;
      #(per);
      serial_in = 1'b1;
      #(2 * per);
      @(negedge tb_clk);
   endtask

   task automatic pop();
      @(negedge tb_clk);
      data_read = 1'b1;
      @(negedge tb_clk);
      data_read = 1'b0;
      @(negedge tb_clk);
   endtask

   initial begin
      logic [7:0] aa;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      serial_in = 1'b1;
      data_read = 1'b0;
      repeat (3) @(negedge tb_clk);
      check("rst_rx_data", rx_data, 8'hFF);
      check("rst_ready", data_ready, 1'b0);
      check("rst_count", fifo_count, 3'd0);
      check("rst_overrun", overrun_error, 1'b0);
      check("rst_framing", framing_error, 1'b0);
      check("rst_parity", parity_error, 1'b0);
      rst = 1'b0;
      repeat (5) @(negedge tb_clk);

      // nominal 0xF0, even parity bit 0
      send_frame(8'hF0, 1'b0, 1'b1, 100);
      check("f0_data", rx_data, 8'hF0);
      check("f0_ready", data_ready, 1'b1);
      check("f0_framing", framing_error, 1'b0);
      check("f0_parity", parity_error, 1'b0);
      check("f0_overrun", overrun_error, 1'b0);
      pop();
      check("f0_pop_ready", data_ready, 1'b0);
      check("f0_pop_data", rx_data, 8'hFF);
      pop();
      check("empty_pop_count", fifo_count, 3'd0);

      // 0x54 has three ones: bit 0 fails even parity (fast line), bit 1 passes (slow line)
      send_frame(8'h54, 1'b0, 1'b1, 96);
      check("p54_bad_parity", parity_error, 1'b1);
      check("p54_bad_ready", data_ready, 1'b0);
      send_frame(8'h54, 1'b1, 1'b1, 104);
      check("p54_good_data", rx_data, 8'h54);
      check("p54_good_parity", parity_error, 1'b0);
      check("p54_good_ready", data_ready, 1'b1);
      pop();

      // stop bit 0, then a clean frame
      send_frame(8'hD3, 1'b1, 1'b0, 100);
      check("d3_framing", framing_error, 1'b1);
      check("d3_count", fifo_count, 3'd0);
      send_frame(8'h12, 1'b0, 1'b1, 100);
      check("x12_framing", framing_error, 1'b0);
      check("x12_data", rx_data, 8'h12);
      check("x12_count", fifo_count, 3'd1);
      pop();

      // half-bit low glitch must be rejected as a false start
      @(posedge tb_clk);
      #3;
      serial_in = 1'b0;
      #50;
      serial_in = 1'b1;
      #1200;
      @(negedge tb_clk);
      check("glitch_count", fifo_count, 3'd0);
      check("glitch_ready", data_ready, 1'b0);
      check("glitch_parity", parity_error, 1'b0);
      check("glitch_framing", framing_error, 1'b0);
      check("glitch_state", dut.state, IDLE);

      // five frames into a four-entry buffer
      send_frame(8'h01, 1'b1, 1'b1, 100);
      send_frame(8'h02, 1'b1, 1'b1, 100);
      send_frame(8'h03, 1'b0, 1'b1, 100);
      send_frame(8'h04, 1'b1, 1'b1, 100);
      send_frame(8'h05, 1'b0, 1'b1, 100);
      check("ovr_count", fifo_count, 3'd4);
      check("ovr_flag", overrun_error, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         check("ovr_pop_data", rx_data, 32'(i));
         pop();
         if (i == 1) begin
            check("ovr_cleared", overrun_error, 1'b0);
         end
      end
      check("ovr_drained", fifo_count, 3'd0);

      // reset in the middle of bit 4 of 0xAA, line held low across the release
      aa = 8'hAA;
      @(posedge tb_clk);
      #3;
      serial_in = 1'b0;
      #100;
      for (int i = 0; i < 4; i++) begin
         serial_in = aa[i];
         #100;
      end
      serial_in = aa[4];
      #50;
      @(negedge tb_clk);
      rst = 1'b1;
      repeat (2) @(negedge tb_clk);
      check("mid_rst_rx_data", rx_data, 8'hFF);
      check("mid_rst_state", dut.state, IDLE);
      rst = 1'b0;
      repeat (30) @(negedge tb_clk);
      check("low_line_state", dut.state, IDLE);
      check("low_line_count", fifo_count, 3'd0);
      serial_in = 1'b1;
      repeat (20) @(negedge tb_clk);
      send_frame(8'h3C, 1'b0, 1'b1, 100);
      check("x3c_data", rx_data, 8'h3C);
      check("x3c_count", fifo_count, 3'd1);
      check("x3c_framing", framing_error, 1'b0);
      check("x3c_parity", parity_error, 1'b0);
      check("x3c_overrun", overrun_error, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
